// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, raises EX hold.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero / signed overflow finish straight from IDLE.
module ex_div #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start_i,
    input  logic [1:0]    op_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [DW-1:0] divisor_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          abort_i,
    output logic          hold_flag_o,
    output logic          busy_o,
    output logic [DW-1:0] result_o,
    output logic          result_valid_o,
    output logic [4:0]    rd_addr_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    quo, rem, dvs, dvd;
    logic [4:0]       rd_r;
    logic             is_rem, neg_q, neg_r, div_zero, ovf;

    logic             in_signed, in_sd, in_ss, in_zero, in_ovf, accept;
    logic [DW-1:0]    in_dvd_mag, in_dvs_mag;

    always_comb begin
        in_signed  = ~op_i[0];
        in_sd      = in_signed & dividend_i[DW-1];
        in_ss      = in_signed & divisor_i[DW-1];
        in_dvd_mag = in_sd ? -dividend_i : dividend_i;
        in_dvs_mag = in_ss ? -divisor_i  : divisor_i;
        in_zero    = (divisor_i == '0);
        in_ovf     = in_signed & (dividend_i == MIN_NEG) & (divisor_i == '1);
        accept     = (state == IDLE) & start_i & ~abort_i;
    end

    // quo starts as |dividend| and shifts out its MSB while quotient bits shift in
    logic [DW:0]   trial;
    logic [DW-1:0] quo_nx, rem_nx, q_fin, r_fin, res_fin;

    always_comb begin
        trial = {rem, quo[DW-1]} - {1'b0, dvs};
        if (!trial[DW]) begin
            rem_nx = trial[DW-1:0];
            quo_nx = {quo[DW-2:0], 1'b1};
        end else begin
            rem_nx = {rem[DW-2:0], quo[DW-1]};
            quo_nx = {quo[DW-2:0], 1'b0};
        end
        q_fin = neg_q ? -quo_nx : quo_nx;
        r_fin = neg_r ? -rem_nx : rem_nx;
        if (div_zero) begin
            q_fin = '1;
            r_fin = dvd;
        end else if (ovf) begin
            q_fin = MIN_NEG;
            r_fin = '0;
        end
        res_fin = is_rem ? r_fin : q_fin;
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic [DW-1:0] fast_res;
    always_comb begin
        if (op_i[1]) fast_res = in_zero ? dividend_i : '0;
        else         fast_res = in_zero ? '1 : MIN_NEG;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            dvd       <= '0;
            rd_r      <= '0;
            is_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_rem   <= op_i[1];
                        neg_q    <= in_sd ^ in_ss;
                        neg_r    <= in_sd;
                        div_zero <= in_zero;
                        ovf      <= in_ovf;
                        dvd      <= dividend_i;
                        dvs      <= in_dvs_mag;
                        quo      <= in_dvd_mag;
                        rem      <= '0;
                        cnt      <= '0;
                        rd_r     <= rd_addr_i;
`ifdef DIV_FAST_SPECIAL_EN
                        if (in_zero || in_ovf) begin
                            result_o  <= fast_res;
                            rd_addr_o <= rd_addr_i;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else begin
                        quo <= quo_nx;
                        rem <= rem_nx;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DW-1)) begin
                            result_o  <= res_fin;
                            rd_addr_o <= rd_r;
                            state     <= DONE;
                        end
                    end
                end
                // start_i is still the same instruction here, so it is not re-accepted
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign hold_flag_o    = accept | ((state == CALC) & ~abort_i);
    assign busy_o         = (state != IDLE);
    assign result_valid_o = (state == DONE) & ~abort_i;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: table vectors, random operands against an arithmetic reference, and
// abort / reset / back-to-back sequences for ex_div (honours DIV_FAST_SPECIAL_EN).
module tb_ex_div;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic [1:0]    op_i;
    logic [DW-1:0] dividend_i;
    logic [DW-1:0] divisor_i;
    logic [4:0]    rd_addr_i;
    logic          abort_i;
    logic          hold_flag_o;
    logic          busy_o;
    logic [DW-1:0] result_o;
    logic          result_valid_o;
    logic [4:0]    rd_addr_o;

    int errors = 0;
    int checks = 0;

    ex_div #(.DW(DW), .CNT_W(6)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start_i        (start_i),
        .op_i           (op_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .rd_addr_i      (rd_addr_i),
        .abort_i        (abort_i),
        .hold_flag_o    (hold_flag_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .rd_addr_o      (rd_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!op[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
        return special ? 1 : DW + 1;
`else
        return special ? DW + 1 : DW + 1;
`endif
    endfunction

    // Start at a negedge, keep start_i high until (and through) the result strobe.
    task automatic run_div(input string nm, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int  cyc, holds, lat;
        bit  seen;
        lat = exp_latency(op, a, b);
        @(negedge clk);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        #1;
        check({nm, " idle_at_start"}, {31'd0, busy_o}, 32'd0);
        cyc   = 0;
        holds = 0;
        seen  = 1'b0;
        while (!seen && cyc < 60) begin
            if (hold_flag_o) holds++;
            if (result_valid_o) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        check({nm, " valid_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({nm, " latency"}, cyc, lat);
            check({nm, " hold_cycles"}, holds, lat);
            check({nm, " result"}, result_o, exp);
            check({nm, " rd_addr"}, {27'd0, rd_addr_o}, {27'd0, rd});
        end
    endtask

    initial begin
        int vcount;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [4:0]  rrd;

        rstn = 1'b0; start_i = 1'b0; op_i = 2'd0; dividend_i = '0; divisor_i = '0;
        rd_addr_i = '0; abort_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset hold", {31'd0, hold_flag_o}, 32'd0);
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset valid", {31'd0, result_valid_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        check("reset rd", {27'd0, rd_addr_o}, 32'd0);
        rstn = 1'b1;

        vecs.push_back('{2'b01, 32'd100,         32'd7,         5'd3,  32'd14});
        vecs.push_back('{2'b00, -32'sd7,         32'd2,         5'd4,  32'hFFFF_FFFD});
        vecs.push_back('{2'b10, -32'sd7,         32'd2,         5'd5,  32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,   32'd16,        5'd6,  32'd15});
        vecs.push_back('{2'b00, 32'd5,           32'd0,         5'd7,  32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'd5,           32'd0,         5'd8,  32'd5});
        vecs.push_back('{2'b00, 32'h8000_0000,   32'hFFFF_FFFF, 5'd9,  32'h8000_0000});
        vecs.push_back('{2'b10, 32'h8000_0000,   32'hFFFF_FFFF, 5'd10, 32'd0});
        vecs.push_back('{2'b00, -32'sd5,         32'd0,         5'd11, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, -32'sd5,         32'd0,         5'd12, 32'hFFFF_FFFB});
        vecs.push_back('{2'b01, 32'd5,           32'd0,         5'd13, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'd7,           32'd0,         5'd14, 32'd7});
        vecs.push_back('{2'b00, 32'd7,           -32'sd2,       5'd15, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, 32'd7,           -32'sd2,       5'd16, 32'd1});
        vecs.push_back('{2'b01, 32'h8000_0000,   32'hFFFF_FFFF, 5'd17, 32'd0});
        vecs.push_back('{2'b11, 32'h8000_0000,   32'hFFFF_FFFF, 5'd18, 32'h8000_0000});
        vecs.push_back('{2'b00, 32'd0,           32'd5,         5'd31, 32'd0});

        vcount = vecs.size();
        for (int i = 0; i < vcount; i++)
            run_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                    vecs[i].exp);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (i == 5) begin rop = 2'b00; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            rrd = 5'($urandom);
            run_div($sformatf("rnd%0d", i), rop, ra, rb, rrd, ref_div(rop, ra, rb));
        end

        // start held through DONE was not re-accepted; line stays idle once start drops
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("no_restart busy", {31'd0, busy_o}, 32'd0);

        // abort in CALC
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd20;
        repeat (10) @(negedge clk);
        abort_i = 1'b1;
        start_i = 1'b0;
        #1;
        check("abort hold", {31'd0, hold_flag_o}, 32'd0);
        check("abort valid", {31'd0, result_valid_o}, 32'd0);
        @(negedge clk);
        abort_i = 1'b0;
        #1;
        check("abort idle", {31'd0, busy_o}, 32'd0);
        check("abort hold_after", {31'd0, hold_flag_o}, 32'd0);
        begin
            int strobes = 0;
            repeat (40) begin
                @(negedge clk);
                #1;
                if (result_valid_o) strobes++;
            end
            check("abort no_result", strobes, 0);
        end

        // abort together with start in IDLE
        @(negedge clk);
        start_i = 1'b1; abort_i = 1'b1;
        #1;
        check("abort_idle hold", {31'd0, hold_flag_o}, 32'd0);
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        #1;
        check("abort_idle busy", {31'd0, busy_o}, 32'd0);

        // reset mid-CALC clears the held result and rd
        run_div("pre_reset", 2'b01, 32'd100, 32'd7, 5'd21, 32'd14);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b01; dividend_i = 32'd500; divisor_i = 32'd9; rd_addr_i = 5'd22;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        #1;
        check("midreset busy", {31'd0, busy_o}, 32'd0);
        check("midreset hold", {31'd0, hold_flag_o}, 32'd0);
        check("midreset valid", {31'd0, result_valid_o}, 32'd0);
        check("midreset result", result_o, 32'd0);
        check("midreset rd", {27'd0, rd_addr_o}, 32'd0);
        rstn = 1'b1;

        run_div("post_reset", 2'b00, -32'sd100, 32'd7, 5'd23, 32'hFFFF_FFF2);
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
